// File: rtl/apvm_delay_line.sv
// Programmable delay line: delays a WIDTH-bit stream by 1..MAX_DELAY enabled cycles
// using a circular buffer; flags out-of-range delay requests and fill-time output.
module apvm_delay_line #(
  parameter int unsigned WIDTH     = 1,
  parameter int unsigned MAX_DELAY = 16,
  parameter int unsigned DLY_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DLY_W-1:0] delay,
  input  logic [WIDTH-1:0] in,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic             out_vld,
  output logic             dly_clamp
);

  localparam int unsigned AW = $clog2(MAX_DELAY);
  localparam int unsigned CW = $clog2(MAX_DELAY + 1);
  localparam logic [AW-1:0] WP_LAST = AW'(MAX_DELAY - 1);
  // Equals 0 when MAX_DELAY is a power of 2, which still yields the right modulo result.
  localparam logic [AW-1:0] DEPTH_A = AW'(MAX_DELAY);
  localparam logic [CW-1:0] FILL_MAX = CW'(MAX_DELAY);

  logic [WIDTH-1:0] mem_q [MAX_DELAY];

  logic [AW-1:0]    wp_q, wp_d;
  logic [CW-1:0]    fill_q, fill_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             vld_q, vld_d;
  logic             clamp_q, clamp_d;

  logic [CW-1:0]    d_eff;
  logic [AW-1:0]    rd_off;
  logic [AW-1:0]    rd_idx;

  // Effective delay and range flag
  always_comb begin
    d_eff   = CW'(delay);
    clamp_d = 1'b0;
    if (delay == '0) begin
      d_eff   = CW'(1);
      clamp_d = 1'b1;
    end else if (delay > DLY_W'(MAX_DELAY)) begin
      d_eff   = FILL_MAX;
      clamp_d = 1'b1;
    end
  end

  // Read index (wp - (d-1)) mod MAX_DELAY without a divider
  always_comb begin
    rd_off = AW'(d_eff - CW'(1));
    if (wp_q >= rd_off) begin
      rd_idx = wp_q - rd_off;
    end else begin
      rd_idx = DEPTH_A - (rd_off - wp_q);
    end
  end

  // Next-state for pointer, fill counter and registered outputs
  always_comb begin
    wp_d   = wp_q;
    fill_d = fill_q;
    vld_d  = 1'b0;
    out_d  = '0;

    wp_d = (wp_q == WP_LAST) ? '0 : wp_q + AW'(1);

    if (fill_q != FILL_MAX) begin
      fill_d = fill_q + CW'(1);
    end

    vld_d = ((CW + 1)'(fill_q) + (CW + 1)'(1)) >= (CW + 1)'(d_eff);

    if (vld_d) begin
      out_d = (d_eff == CW'(1)) ? in : mem_q[rd_idx];
    end
  end

  // Control state; en=0 freezes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q    <= '0;
      fill_q  <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      clamp_q <= 1'b0;
    end else if (en) begin
      wp_q    <= wp_d;
      fill_q  <= fill_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      clamp_q <= clamp_d;
    end
  end

  // Sample storage is not reset; stale contents are masked by out_vld
  always_ff @(posedge clk) begin
    if (en) begin
      mem_q[wp_q] <= in;
    end
  end

  assign out       = out_q;
  assign out_vld   = vld_q;
  assign dly_clamp = clamp_q;

endmodule

// File: tb/tb_apvm_delay_line.sv
// Directed bench for apvm_delay_line: two instances (MAX_DELAY 16 and 12) share
// clock, reset, enable and data; each has its own delay request.
module tb_apvm_delay_line;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [W-1:0] din;
  logic [31:0]  dly16, dly12;
  logic [W-1:0] out16, out12;
  logic         vld16, vld12, clp16, clp12;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  apvm_delay_line #(.WIDTH(W), .MAX_DELAY(16), .DLY_W(32)) u16 (
    .clk(clk), .rst_n(rst_n), .delay(dly16), .in(din), .en(en),
    .out(out16), .out_vld(vld16), .dly_clamp(clp16)
  );

  apvm_delay_line #(.WIDTH(W), .MAX_DELAY(12), .DLY_W(32)) u12 (
    .clk(clk), .rst_n(rst_n), .delay(dly12), .in(din), .en(en),
    .out(out12), .out_vld(vld12), .dly_clamp(clp12)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int eff(input int d, input int mx);
    if (d == 0) return 1;
    if (d > mx) return mx;
    return d;
  endfunction

  // Reset between edges; outputs must clear without waiting for a clock
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #2;
    chk({tag, " out16"}, 32'(out16), 0);
    chk({tag, " vld16"}, 32'(vld16), 0);
    chk({tag, " clp16"}, 32'(clp16), 0);
    chk({tag, " out12"}, 32'(out12), 0);
    chk({tag, " vld12"}, 32'(vld12), 0);
    chk({tag, " clp12"}, 32'(clp12), 0);
    rst_n = 1'b1;
  endtask

  // One enabled edge with in = e; expected out is the sample from edge e-d+1
  task automatic ramp_edge(input int e, input int d16, input int d12);
    int f16;
    int f12;
    en    = 1'b1;
    din   = W'(e);
    dly16 = 32'(d16);
    dly12 = 32'(d12);
    tick();
    f16 = eff(d16, 16);
    f12 = eff(d12, 12);
    chk($sformatf("vld16 e%0d d%0d", e, d16), 32'(vld16), 32'(e >= f16));
    chk($sformatf("out16 e%0d d%0d", e, d16), 32'(out16), (e >= f16) ? 32'((e - f16 + 1) & 255) : 0);
    chk($sformatf("clp16 e%0d d%0d", e, d16), 32'(clp16), 32'(d16 != f16));
    chk($sformatf("vld12 e%0d d%0d", e, d12), 32'(vld12), 32'(e >= f12));
    chk($sformatf("out12 e%0d d%0d", e, d12), 32'(out12), (e >= f12) ? 32'((e - f12 + 1) & 255) : 0);
    chk($sformatf("clp12 e%0d d%0d", e, d12), 32'(clp12), 32'(d12 != f12));
  endtask

  initial begin
    logic [W-1:0] samp [0:31];
    logic [W-1:0] exp_out;
    logic         exp_vld;
    int           k;
    bit           on;

    rst_n = 1'b0;
    en    = 1'b0;
    din   = '0;
    dly16 = 32'd5;
    dly12 = 32'd5;

    // Basic latency, delay 5
    do_reset("por");
    for (int e = 1; e <= 20; e++) ramp_edge(e, 5, 5);

    // Minimum delay (u16) and delay 0 clamped to 1 (u12)
    do_reset("min");
    for (int e = 1; e <= 6; e++) begin
      en    = 1'b1;
      din   = (e % 2 == 1) ? 8'hA5 : 8'h5A;
      dly16 = 32'd1;
      dly12 = 32'd0;
      tick();
      chk($sformatf("min out16 e%0d", e), 32'(out16), 32'(din));
      chk($sformatf("min vld16 e%0d", e), 32'(vld16), 1);
      chk($sformatf("min clp16 e%0d", e), 32'(clp16), 0);
      chk($sformatf("zero out12 e%0d", e), 32'(out12), 32'(din));
      chk($sformatf("zero vld12 e%0d", e), 32'(vld12), 1);
      chk($sformatf("zero clp12 e%0d", e), 32'(clp12), 1);
    end

    // Oversized request clamps to MAX_DELAY, then an in-range request clears the flag
    do_reset("big");
    for (int e = 1; e <= 20; e++) ramp_edge(e, 40, 40);
    ramp_edge(21, 7, 7);
    ramp_edge(22, 7, 7);

    // Enable gating at delay 4; delay is junk on disabled cycles
    do_reset("gate");
    k       = 0;
    exp_out = '0;
    exp_vld = 1'b0;
    for (int i = 0; i < 20; i++) begin
      on    = (i % 2 == 0);
      en    = on;
      din   = W'(100 + i);
      dly16 = on ? 32'd4 : 32'd0;
      dly12 = on ? 32'd4 : 32'd99;
      tick();
      if (on) begin
        k++;
        samp[k] = W'(100 + i);
        exp_vld = (k >= 4);
        exp_out = (k >= 4) ? samp[k - 3] : '0;
      end
      chk($sformatf("gate out16 i%0d", i), 32'(out16), 32'(exp_out));
      chk($sformatf("gate vld16 i%0d", i), 32'(vld16), 32'(exp_vld));
      chk($sformatf("gate clp16 i%0d", i), 32'(clp16), 0);
      chk($sformatf("gate out12 i%0d", i), 32'(out12), 32'(exp_out));
      chk($sformatf("gate clp12 i%0d", i), 32'(clp12), 0);
    end

    // Long run through several pointer wraps, then on-the-fly delay changes
    do_reset("wrap");
    for (int e = 1; e <= 40; e++) ramp_edge(e, 3, 3);
    ramp_edge(41, 10, 12);
    ramp_edge(42, 10, 12);
    ramp_edge(43, 2, 5);
    ramp_edge(44, 3, 13);
    ramp_edge(45, 2, 11);
    ramp_edge(46, 16, 1);

    // Reset in the middle of a stream, then exact refill latency
    do_reset("pre");
    for (int e = 1; e <= 10; e++) ramp_edge(e, 6, 20);
    do_reset("mid");
    for (int e = 1; e <= 8; e++) ramp_edge(e, 6, 6);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/apvm_delay_line.md
Name: apvm_delay_line

Overview:
- Synthesizable, clocked successor to the behavioural delay element.
- Delays a WIDTH-bit input by a run-time programmable number of enabled clock cycles, from 1 to MAX_DELAY.
- Storage is a circular buffer. The clock enable freezes the line.
- Reports output validity and out-of-range delay requests. It sits wherever the behavioural delay was used, but runs in the synthesizable clock domain.

Parameters:
- WIDTH, 1: data width of in/out.
- MAX_DELAY, 16: maximum delay in enabled cycles, ≥2. Buffer depth is MAX_DELAY.
- DLY_W, 32: width of the delay input.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- delay  input  DLY_W  requested delay in enabled cycles, unsigned.
- in  input  WIDTH  data sampled on enabled edges.
- en  input  1  clock enable; when low, all state holds.
- out  output  WIDTH  delayed data, registered.
- out_vld  output  1  out carries a real sample (not fill), registered.
- dly_clamp  output  1  delay was out of range on the last enabled edge, registered.

Behaviour:
- Interface (already decided): one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset: out=0, out_vld=0, dly_clamp=0, write pointer=0, fill counter=0. Buffer contents are not reset; they are don't-care, masked by out_vld.
- Effective delay d:
  - delay==0 → d=1, dly_clamp=1.
  - delay>MAX_DELAY → d=MAX_DELAY, dly_clamp=1.
  - Otherwise d=delay, dly_clamp=0.
  - dly_clamp updates only on enabled edges.
- Enabled edge (en=1), in order:
  - mem[wp] <= in.
  - wp <= (wp+1) mod MAX_DELAY.
  - fill <= min(fill+1, MAX_DELAY).
  - out <= (d==1) ? in : mem[(wp-(d-1)) mod MAX_DELAY]. The read uses pre-edge wp and pre-edge mem contents.
  - out_vld <= (fill+1 >= d). Uses pre-edge fill.
  - When the computed out_vld is 0, out <= 0.
- Latency: in sampled on enabled edge k appears on out right after enabled edge k+d-1. That is d enabled cycles, identical to a d-stage shift register.
- en=0: no state changes. out, out_vld and dly_clamp hold. Disabled cycles do not count toward delay.
- Delay change: takes effect on the next enabled edge, with no flush.
  - Decrease by n: the n intermediate samples are skipped.
  - Increase by n: the old samples are replayed (the stream moves back n samples).
  - out_vld re-evaluates against fill. After reset, fill has saturated once ≥MAX_DELAY enabled edges occur, so any in-range increase stays valid.
- Pointer wrap: wp wraps MAX_DELAY-1→0. Read-index subtraction is modulo MAX_DELAY. It must be correct when MAX_DELAY is not a power of 2.
- The fill counter saturates at MAX_DELAY and never wraps.
- Reset mid-operation: all registered outputs and counters return to reset values immediately (asynchronous). The first post-reset out_vld rises only after d enabled edges.
- delay is sampled only on enabled edges. It need not be stable on disabled cycles.

Test Plan:
- Basic latency: WIDTH=8, MAX_DELAY=16, delay=5, en=1, in=1,2,3,… from reset → out_vld rises after edge 5 with out=1; then out=in-5+1 on every following edge.
- Minimum delay: delay=1, in toggling 0xA5/0x5A → out follows in one cycle late. out_vld=1 after the first edge.
- Enable gating: delay=4, ramp input with en low every other cycle → out advances only on enabled edges and holds otherwise. Latency is 4 enabled edges.
- Clamping:
  - delay=0 → behaves as delay=1, dly_clamp=1.
  - delay=40 with MAX_DELAY=16 → behaves as 16, dly_clamp=1.
  - delay=7 → dly_clamp=0.
- Delay change and wrap: run 40 enabled cycles at delay=3, then switch to delay=10 → out steps back 7 samples with out_vld staying 1. Switch to 2 → one sample skipped. Also cover wrap with MAX_DELAY=12 (not a power of 2).
- Reset mid-stream: assert rst_n low between edges at delay=6 → out, out_vld and dly_clamp go 0 immediately. After release, out_vld reasserts after exactly 6 enabled edges.
